// File: rtl/keypad_scan_read_if.sv
// Keypad-side signal bundle: matrix row/column lines plus the decoded key outputs.
// master = scanner/decoder, slave = keypad and downstream digit logic.
interface keypad_scan_read_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  rows,
    output cols,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output rows,
    input  cols,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_read.sv
// 4x4 matrix keypad scanner: walks a low column across the matrix, debounces press
// and release of a single key, and emits one hex code pulse per physical press.
module keypad_scan_read #(
  parameter int unsigned SCAN_DIV        = 32'd2000,
  parameter int unsigned DEBOUNCE_CYCLES = 32'd50000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  keypad_scan_read_if.master    kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  state_t           state;
  logic [3:0]       rows_meta;
  logic [3:0]       rows_sync;
  logic [1:0]       col_idx;
  logic [1:0]       row_idx;
  logic [3:0]       row_pat;
  logic [DIV_W-1:0] div_ctr;
  logic [DEB_W-1:0] deb_ctr;
  logic [3:0]       cols_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;

  // A press is only trusted when a single row is pulled low; ghosting from
  // multiple closed keys shows up as two or more low rows.
  function automatic logic single_low(input logic [3:0] r);
    logic res;
    case (r)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] r);
    logic [1:0] idx;
    case (r)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rows_meta <= 4'b1111;
      rows_sync <= 4'b1111;
    end else begin
      rows_meta <= kp.rows;
      rows_sync <= rows_meta;
    end
  end

  // Column stays frozen from press detection until the release is debounced, so
  // the latched row keeps reading the same key throughout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SCAN;
      col_idx     <= 2'd0;
      cols_q      <= 4'b1110;
      row_idx     <= 2'd0;
      row_pat     <= 4'b1111;
      div_ctr     <= '0;
      deb_ctr     <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      case (state)
        SCAN: begin
          if (div_ctr == DIV_LAST) begin
            div_ctr <= '0;
            deb_ctr <= '0;
            if (single_low(rows_sync)) begin
              row_pat <= rows_sync;
              row_idx <= low_index(rows_sync);
              state   <= DEB_PRESS;
            end else begin
              col_idx <= col_idx + 2'd1;
              cols_q  <= {cols_q[2:0], cols_q[3]};
            end
          end else begin
            div_ctr <= div_ctr + DIV_W'(1);
          end
        end

        DEB_PRESS: begin
          if (rows_sync != row_pat) begin
            state   <= SCAN;
            div_ctr <= '0;
            deb_ctr <= '0;
            col_idx <= col_idx + 2'd1;
            cols_q  <= {cols_q[2:0], cols_q[3]};
          end else if (deb_ctr == DEB_LAST) begin
            state       <= HELD;
            deb_ctr     <= '0;
            key_code_q  <= key_map(row_idx, col_idx);
            key_valid_q <= 1'b1;
            key_held_q  <= 1'b1;
          end else begin
            deb_ctr <= deb_ctr + DEB_W'(1);
          end
        end

        // Only the latched row matters here; other keys are deliberately ignored.
        HELD: begin
          if (rows_sync[row_idx]) begin
            state   <= DEB_REL;
            deb_ctr <= '0;
          end
        end

        DEB_REL: begin
          if (!rows_sync[row_idx]) begin
            state   <= HELD;
            deb_ctr <= '0;
          end else if (deb_ctr == DEB_LAST) begin
            state      <= SCAN;
            deb_ctr    <= '0;
            div_ctr    <= '0;
            key_held_q <= 1'b0;
            col_idx    <= col_idx + 2'd1;
            cols_q     <= {cols_q[2:0], cols_q[3]};
          end else begin
            deb_ctr <= deb_ctr + DEB_W'(1);
          end
        end

        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

  assign kp.cols      = cols_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_read.sv
// Bench for keypad_scan_read: a switch-matrix keypad model, a key-table sweep,
// randomized presses against a key-map reference, and the multi-cycle corner cases.
module tb_keypad_scan_read;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int LATENCY  = 4 * SCAN_DIV + 2 + DEB + 1;

  logic        clk;
  logic        reset_n;
  logic [15:0] pressed;
  logic [3:0]  rows_model;
  logic [63:0] map_word = 64'h123A_456B_789C_E0FD;

  int checks = 0;
  int errors = 0;
  int pulse_count = 0;
  logic [3:0] pulse_code = 4'h0;

  keypad_scan_read_if kif ();

  keypad_scan_read #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kp      (kif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A closed switch ties its row to its column, so a row reads low only while
  // the column of one of its closed keys is driven low.
  always_comb begin
    rows_model = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.cols[c]) rows_model[r] = 1'b0;
  end
  assign kif.rows = rows_model;

  typedef struct {
    int         row;
    int         col;
    int         hold;
    int         exp_pulses;
    logic [3:0] exp_code;
  } vec_t;

  vec_t vecs[18];

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [3:0] ref_key(input int r, input int c);
    return map_word[63-4*(r*4+c) -: 4];
  endfunction

  task automatic set_key(input int r, input int c, input logic v);
    pressed[r*4+c] = v;
  endtask

  task automatic apply_stimulus(input int r, input int c, input int hold, input int gap);
    set_key(r, c, 1'b1);
    repeat (hold) @(negedge clk);
    set_key(r, c, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  // Pulses are counted just after each edge so a stretched pulse counts twice.
  always @(posedge clk) begin
    #1;
    if (kif.key_valid) begin
      pulse_count++;
      pulse_code = kif.key_code;
      check_output("valid_implies_held", int'(kif.key_held), 1);
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int p0;
    int n;
    int bad;
    int seen;
    int changes;
    logic [3:0] prev_cols;
    logic [3:0] exp_cols;
    logic [3:0] model_code;
    int r;
    int c;
    int hold;
    int exp_p;

    vecs[0]  = '{0, 0, 50, 1, 4'h1};
    vecs[1]  = '{0, 1, 50, 1, 4'h2};
    vecs[2]  = '{0, 2, 50, 1, 4'h3};
    vecs[3]  = '{0, 3, 50, 1, 4'hA};
    vecs[4]  = '{1, 0, 50, 1, 4'h4};
    vecs[5]  = '{1, 1, 50, 1, 4'h5};
    vecs[6]  = '{1, 2, 50, 1, 4'h6};
    vecs[7]  = '{1, 3, 50, 1, 4'hB};
    vecs[8]  = '{2, 0, 50, 1, 4'h7};
    vecs[9]  = '{2, 1, 50, 1, 4'h8};
    vecs[10] = '{2, 2, 50, 1, 4'h9};
    vecs[11] = '{2, 3, 50, 1, 4'hC};
    vecs[12] = '{3, 0, 50, 1, 4'hE};
    vecs[13] = '{3, 1, 50, 1, 4'h0};
    vecs[14] = '{3, 2, 50, 1, 4'hF};
    vecs[15] = '{3, 3, 50, 1, 4'hD};
    vecs[16] = '{1, 2,  5, 0, 4'hD};
    vecs[17] = '{0, 1,  3, 0, 4'hD};

    pressed = 16'h0;
    reset_n = 1'b0;

    // Reset values, then free-running scan with no keys.
    repeat (2) @(negedge clk);
    check_output("reset_cols", int'(kif.cols), 32'hE);
    check_output("reset_key_code", int'(kif.key_code), 0);
    check_output("reset_key_valid", int'(kif.key_valid), 0);
    check_output("reset_key_held", int'(kif.key_held), 0);
    reset_n = 1'b1;
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_cols = ~(4'b0001 << ((k / 4) % 4));
      if (kif.cols != exp_cols) bad++;
    end
    check_output("idle_scan_sequence_bad_cycles", bad, 0);

    $display("[TB] key table sweep");
    for (int i = 0; i < 18; i++) begin
      p0 = pulse_count;
      apply_stimulus(vecs[i].row, vecs[i].col, vecs[i].hold, 30);
      check_output($sformatf("table%0d_pulses", i), pulse_count - p0, vecs[i].exp_pulses);
      check_output($sformatf("table%0d_code", i), int'(kif.key_code), int'(vecs[i].exp_code));
    end

    $display("[TB] hold key 5");
    p0 = pulse_count;
    bad = 0;
    seen = 0;
    set_key(1, 1, 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (kif.key_held) begin
        seen = 1;
        if (kif.cols != 4'b1101) bad++;
      end else if (seen != 0) begin
        bad++;
      end
    end
    check_output("k5_held_seen", seen, 1);
    check_output("k5_hold_bad_cycles", bad, 0);
    set_key(1, 1, 1'b0);
    n = 0;
    while (kif.key_held && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_output("k5_release_delay_in_range", int'(n >= 8 && n <= 12), 1);
    check_output("k5_pulses", pulse_count - p0, 1);
    check_output("k5_code", int'(pulse_code), 5);
    repeat (10) @(negedge clk);

    $display("[TB] bouncing key 9");
    p0 = pulse_count;
    for (int i = 0; i < 100; i++) begin
      if (i % 3 == 0) pressed[10] = ~pressed[10];
      @(negedge clk);
    end
    pressed[10] = 1'b0;
    check_output("bounce_pulses", pulse_count - p0, 0);
    check_output("bounce_code_kept", int'(kif.key_code), 5);
    changes = 0;
    prev_cols = kif.cols;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kif.cols != prev_cols) changes++;
      prev_cols = kif.cols;
    end
    check_output("bounce_scan_continues", int'(changes >= 5), 1);

    $display("[TB] hold key D with release glitch");
    p0 = pulse_count;
    bad = 0;
    seen = 0;
    set_key(3, 3, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) set_key(3, 3, 1'b0);
      if (i == 503) set_key(3, 3, 1'b1);
      @(negedge clk);
      if (kif.key_held) begin
        seen = 1;
        if (kif.cols != 4'b0111) bad++;
      end else if (seen != 0) begin
        bad++;
      end
    end
    check_output("kD_held_seen", seen, 1);
    check_output("kD_glitch_bad_cycles", bad, 0);
    set_key(3, 3, 1'b0);
    repeat (30) @(negedge clk);
    check_output("kD_pulses", pulse_count - p0, 1);
    check_output("kD_code", int'(pulse_code), 32'hD);
    check_output("kD_released", int'(kif.key_held), 0);

    $display("[TB] keys 1 and 4 together");
    p0 = pulse_count;
    set_key(0, 0, 1'b1);
    set_key(1, 0, 1'b1);
    repeat (100) @(negedge clk);
    check_output("two_keys_no_pulse", pulse_count - p0, 0);
    set_key(1, 0, 1'b0);
    n = 0;
    while (pulse_count == p0 && n < LATENCY + 10) begin
      @(negedge clk);
      n++;
    end
    check_output("after_release4_pulses", pulse_count - p0, 1);
    check_output("after_release4_code", int'(pulse_code), 1);
    set_key(0, 0, 1'b0);
    repeat (30) @(negedge clk);

    $display("[TB] reset while key 0 held");
    p0 = pulse_count;
    set_key(3, 1, 1'b1);
    n = 0;
    while (pulse_count == p0 && n < LATENCY + 10) begin
      @(negedge clk);
      n++;
    end
    check_output("k0_first_pulse", pulse_count - p0, 1);
    repeat (5) @(negedge clk);
    check_output("k0_held_before_reset", int'(kif.key_held), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("midreset_cols", int'(kif.cols), 32'hE);
    check_output("midreset_held", int'(kif.key_held), 0);
    check_output("midreset_valid", int'(kif.key_valid), 0);
    check_output("midreset_code", int'(kif.key_code), 0);
    @(negedge clk);
    reset_n = 1'b1;
    p0 = pulse_count;
    n = 0;
    while (pulse_count == p0 && n < LATENCY + 2) begin
      @(negedge clk);
      n++;
    end
    check_output("k0_redetect_pulses", pulse_count - p0, 1);
    check_output("k0_redetect_code", int'(pulse_code), 0);
    set_key(3, 1, 1'b0);
    repeat (30) @(negedge clk);

    $display("[TB] randomized presses");
    model_code = kif.key_code;
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        hold  = int'($urandom_range(1, 6));
        exp_p = 0;
      end else begin
        hold       = int'($urandom_range(45, 90));
        exp_p      = 1;
        model_code = ref_key(r, c);
      end
      p0 = pulse_count;
      apply_stimulus(r, c, hold, 30);
      check_output($sformatf("rand%0d_pulses", i), pulse_count - p0, exp_p);
      check_output($sformatf("rand%0d_code", i), int'(kif.key_code), int'(model_code));
      check_output($sformatf("rand%0d_released", i), int'(kif.key_held), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
